mem_bus_responder: RTL and testbench
====================================

// Module: mem_bus_responder
// PURPOSE
//  Behavioural memory slave for the core's req/gnt memory bus (one instance each on imem and dmem).
//  Drives gnt/err/rdata with pseudo-random bounded stalls, a configurable error region and a
//  byte-strobed word store, so stimulus stays inside the bus fairness constraints used for formal.
//  Sits directly downstream of the core memory ports, in both the simulation and formal harnesses.
// PARAMETERS
//  MEM_ADDR_W  64                     request address width
//  MEM_STRB_W  8                      write strobe width (one bit per data byte)
//  MEM_DATA_W  64                     data width
//  DEPTH_W     10                     log2 of store depth in words (2^DEPTH_W words)
//  MAX_DELAY   4                      max stall cycles before gnt (must be < 5 for fairness)
//  ERR_BASE    'h0000_0000_0000_1000  base of forced-error region
//  ERR_MASK    'hFFFF_FFFF_FFFF_F000  region match mask: (addr & ERR_MASK) == ERR_BASE
//  LFSR_SEED   16'hACE1               stall LFSR seed (0 is replaced by 1)
// PORTS
//  g_clk          in   1             global clock
//  g_reset        in   1             synchronous active-high reset
//  mem_req        in   1             request valid; held with stable payload until gnt
//  mem_addr       in   MEM_ADDR_W    byte address; low log2(MEM_STRB_W) bits ignored
//  mem_wen        in   1             1 = write, 0 = read
//  mem_strb       in   MEM_STRB_W    byte write enables
//  mem_wdata      in   MEM_DATA_W    write data
//  mem_gnt        out  1             request accepted this cycle (combinational)
//  mem_err        out  1             response error; valid the cycle after gnt
//  mem_rdata      out  MEM_DATA_W    read data; valid the cycle after gnt
//  stall_en       in   1             0 = grant every request in its first cycle
//  proto_err      out  1             sticky: req dropped before gnt
//  txn_count      out  32            number of grants since reset, wraps at 2^32
// BEHAVIOUR
//  Reset: FSM=IDLE, stall_cnt=0, lfsr=LFSR_SEED, mem_err=0, mem_rdata=0, proto_err=0,
//   txn_count=0; mem_gnt forced 0 while g_reset=1. Store contents are not reset.
//  Stall draw: d = stall_en ? (lfsr[7:0] % (MAX_DELAY+1)) : 0. The LFSR is a 16-bit Galois LFSR
//   with taps 16,14,13,11 and steps only in cycles where IDLE && mem_req.
//  FSM IDLE: mem_req && d==0 -> mem_gnt=1, stay IDLE; mem_req && d!=0 -> WAIT, stall_cnt=d-1.
//  FSM WAIT: mem_req && stall_cnt==0 -> mem_gnt=1, go IDLE; mem_req && stall_cnt!=0 -> decrement;
//   !mem_req -> proto_err<=1, go IDLE, no gnt.
//  Latency: gnt arrives at most MAX_DELAY cycles after req first rises; response is 1 cycle after gnt.
//  Address decode: idx = addr[DEPTH_W+2:3] for 64-bit data.
//   oob = any addr bit above DEPTH_W+2 is set; rgn = (addr & ERR_MASK) == ERR_BASE;
//   err = oob || rgn, evaluated in the gnt cycle.
//  Grant cycle, write, !err: store[idx] byte k <= wdata byte k for each strb[k]=1.
//   Registered response: mem_err=0, mem_rdata=0.
//  Grant cycle, read, !err: mem_rdata <= store[idx] (pre-write value; reads and writes never
//   share a cycle). mem_err <= 0.
//  Grant cycle, err: no store update; mem_err <= 1; mem_rdata <= 0.
//  Non-grant cycle: mem_err <= 0 and mem_rdata <= 0. Outputs are zero whenever no response is due.
//  Back-to-back: a new req in the cycle after gnt is decoded normally. A read of a just-written
//   word returns the new data.
//  txn_count increments on every gnt, including errored grants, and wraps to 0.
//  Reset mid-WAIT: aborts without gnt. A response due in the reset cycle is dropped (outputs 0).
// TESTING
//  stall_en=0, write addr 0x40 strb 0xFF data 0x1122334455667788, then read 0x40
//   -> gnt in the same cycle as each req; the next cycle has err=0, rdata=0x1122334455667788.
//  Partial write strb=0x0F data 0xAAAAAAAAAAAAAAAA to 0x40 after the above, then read
//   -> rdata=0x11223344AAAAAAAA.
//  Read 0x1008 (error region) and read 0x2000_0000 (oob)
//   -> err=1 and rdata=0 in each response cycle; store unchanged.
//  stall_en=1, 1000 random reqs held until gnt
//   -> every req-to-gnt wait <= 4 cycles, at least one wait of 0 and one of 4, txn_count=1000.
//  Drop req in WAIT -> proto_err=1 and stays 1 until g_reset; no gnt for the dropped req.
//  Assert g_reset in WAIT and in the response cycle -> gnt=0, err=0, rdata=0, txn_count=0 next
//   cycle; data written before reset is still readable after it.

Source files
------------

// File: rtl/mem_bus_responder_if.sv
// Request/grant memory bus between a core memory port and its responder.
// Master drives req/addr/wen/strb/wdata; slave drives gnt/err/rdata.
interface mem_bus_responder_if #(
    parameter int MEM_ADDR_W = 64,
    parameter int MEM_STRB_W = 8,
    parameter int MEM_DATA_W = 64
);
    logic                  mem_req;
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic                  mem_wen;
    logic [MEM_STRB_W-1:0] mem_strb;
    logic [MEM_DATA_W-1:0] mem_wdata;
    logic                  mem_gnt;
    logic                  mem_err;
    logic [MEM_DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        output mem_wen,
        output mem_strb,
        output mem_wdata,
        input  mem_gnt,
        input  mem_err,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        input  mem_wen,
        input  mem_strb,
        input  mem_wdata,
        output mem_gnt,
        output mem_err,
        output mem_rdata
    );
endinterface

// File: rtl/mem_bus_responder.sv
// Behavioural memory slave: LFSR-bounded grant stalls, error region, byte-strobed store.
// Ports: g_clk, g_reset (sync, active high), bus (slave modport), stall_en, proto_err, txn_count.
module mem_bus_responder #(
    parameter int                    MEM_ADDR_W = 64,
    parameter int                    MEM_STRB_W = 8,
    parameter int                    MEM_DATA_W = 64,
    parameter int                    DEPTH_W    = 10,
    parameter int                    MAX_DELAY  = 4,
    parameter logic [MEM_ADDR_W-1:0] ERR_BASE   = 'h0000_0000_0000_1000,
    parameter logic [MEM_ADDR_W-1:0] ERR_MASK   = 'hFFFF_FFFF_FFFF_F000,
    parameter logic [15:0]           LFSR_SEED  = 16'hACE1
) (
    input  logic                g_clk,
    input  logic                g_reset,
    mem_bus_responder_if.slave  bus,
    input  logic                stall_en,
    output logic                proto_err,
    output logic [31:0]         txn_count
);
    localparam int          OFF_W     = $clog2(MEM_STRB_W);
    localparam int          DEPTH     = 1 << DEPTH_W;
    localparam int          BYTE_W    = MEM_DATA_W / MEM_STRB_W;
    localparam logic [7:0]  DRAW_DIV  = 8'(MAX_DELAY + 1);
    // An all-zero Galois LFSR would lock up.
    localparam logic [15:0] LFSR_INIT = (LFSR_SEED == 16'h0) ? 16'h1 : LFSR_SEED;
    // Taps 16,14,13,11 for a right-shifting Galois LFSR.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t                r_state;
    logic [7:0]            r_stall_cnt;
    logic [15:0]           r_lfsr;
    logic                  r_err;
    logic [MEM_DATA_W-1:0] r_rdata;
    logic                  r_proto_err;
    logic [31:0]           r_txn_count;
    logic [MEM_DATA_W-1:0] r_mem [DEPTH];

    logic [7:0]            w_draw;
    logic [15:0]           w_lfsr_nxt;
    logic [DEPTH_W-1:0]    w_idx;
    logic                  w_oob;
    logic                  w_rgn;
    logic                  w_err;
    logic                  w_gnt;
    logic                  w_wr;
    logic                  w_rd;

    assign w_draw     = stall_en ? (r_lfsr[7:0] % DRAW_DIV) : 8'd0;
    assign w_lfsr_nxt = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_TAPS)
                                  : (r_lfsr >> 1);

    assign w_idx = bus.mem_addr[DEPTH_W+OFF_W-1:OFF_W];
    assign w_oob = |(bus.mem_addr >> (DEPTH_W + OFF_W));
    assign w_rgn = (bus.mem_addr & ERR_MASK) == ERR_BASE;
    assign w_err = w_oob || w_rgn;

    // Grant in IDLE when no stall was drawn, or in WAIT once the count is spent.
    always_comb begin
        w_gnt = 1'b0;
        if (!g_reset && bus.mem_req) begin
            unique case (r_state)
                S_IDLE:  w_gnt = (w_draw == 8'd0);
                S_WAIT:  w_gnt = (r_stall_cnt == 8'd0);
                default: w_gnt = 1'b0;
            endcase
        end
    end

    assign w_wr = w_gnt && bus.mem_wen && !w_err;
    assign w_rd = w_gnt && !bus.mem_wen && !w_err;

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_state     <= S_IDLE;
            r_stall_cnt <= 8'd0;
            r_lfsr      <= LFSR_INIT;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_proto_err <= 1'b0;
            r_txn_count <= 32'd0;
        end else begin
            r_err   <= w_gnt && w_err;
            r_rdata <= w_rd ? r_mem[w_idx] : '0;
            if (w_gnt) begin
                r_txn_count <= r_txn_count + 32'd1;
            end
            unique case (r_state)
                S_IDLE: begin
                    // One LFSR step per request arriving in IDLE.
                    if (bus.mem_req) begin
                        r_lfsr <= w_lfsr_nxt;
                        if (w_draw != 8'd0) begin
                            r_state     <= S_WAIT;
                            r_stall_cnt <= w_draw - 8'd1;
                        end
                    end
                end
                S_WAIT: begin
                    if (!bus.mem_req) begin
                        r_proto_err <= 1'b1;
                        r_state     <= S_IDLE;
                    end else if (r_stall_cnt == 8'd0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_stall_cnt <= r_stall_cnt - 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Store is deliberately not reset so contents survive g_reset.
    always_ff @(posedge g_clk) begin
        if (w_wr) begin
            for (int k = 0; k < MEM_STRB_W; k++) begin
                if (bus.mem_strb[k]) begin
                    r_mem[w_idx][k*BYTE_W +: BYTE_W] <= bus.mem_wdata[k*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // A response falling in a reset cycle is dropped.
    assign bus.mem_gnt   = w_gnt;
    assign bus.mem_err   = r_err && !g_reset;
    assign bus.mem_rdata = g_reset ? '0 : r_rdata;
    assign proto_err     = r_proto_err;
    assign txn_count     = r_txn_count;
endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder.
// Random and directed traffic against a transaction-level store/stall model.
module tb_mem_bus_responder;
    logic        g_clk = 1'b0;
    logic        g_reset;
    logic        stall_en;
    logic        proto_err;
    logic [31:0] txn_count;

    mem_bus_responder_if bus ();

    mem_bus_responder dut (
        .g_clk     (g_clk),
        .g_reset   (g_reset),
        .bus       (bus),
        .stall_en  (stall_en),
        .proto_err (proto_err),
        .txn_count (txn_count)
    );

    always #5 g_clk = ~g_clk;

    int          n_chk;
    int          n_fail;
    logic [63:0] m_mem [1024];
    logic [15:0] m_lfsr;
    int          m_gnts;
    bit          pend;
    logic        exp_err;
    logic [63:0] exp_rdata;
    logic        last_err;
    logic [63:0] last_rdata;
    bit          seen0;
    bit          seen4;
    int          max_w;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_is_err(input logic [63:0] a);
        return (a >= 64'h2000) ||
               ((a & 64'hFFFF_FFFF_FFFF_F000) == 64'h1000);
    endfunction

    function automatic int m_draw();
        return stall_en ? (int'(m_lfsr[7:0]) % 5) : 0;
    endfunction

    function automatic logic [15:0] m_step(input logic [15:0] l);
        // x^16 + x^14 + x^13 + x^11 + 1, Galois form
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    task automatic check_rsp();
        last_err   = bus.mem_err;
        last_rdata = bus.mem_rdata;
        if (pend) begin
            chk("rsp_err", {63'd0, bus.mem_err}, {63'd0, exp_err});
            chk("rsp_rdata", bus.mem_rdata, exp_rdata);
        end else begin
            chk("idle_err", {63'd0, bus.mem_err}, 64'd0);
            chk("idle_rdata", bus.mem_rdata, 64'd0);
        end
        pend = 1'b0;
    endtask

    task automatic run_txn(input logic [63:0] a, input logic w,
                           input logic [7:0] s, input logic [63:0] d);
        int exp_w;
        int wcnt;
        bit got;
        int idx;
        exp_w  = m_draw();
        m_lfsr = m_step(m_lfsr);
        @(posedge g_clk); #1;
        bus.mem_req   = 1'b1;
        bus.mem_addr  = a;
        bus.mem_wen   = w;
        bus.mem_strb  = s;
        bus.mem_wdata = d;
        wcnt = 0;
        got  = 1'b0;
        while (!got && wcnt <= 8) begin
            @(negedge g_clk);
            check_rsp();
            if (bus.mem_gnt) begin
                got = 1'b1;
            end else begin
                wcnt++;
                @(posedge g_clk); #1;
            end
        end
        if (!got) begin
            chk("gnt_timeout", 64'(wcnt), 64'(exp_w));
            bus.mem_req = 1'b0;
            return;
        end
        chk("gnt_wait", 64'(wcnt), 64'(exp_w));
        if (wcnt == 0) seen0 = 1'b1;
        if (wcnt == 4) seen4 = 1'b1;
        if (wcnt > max_w) max_w = wcnt;
        idx       = int'(a[12:3]);
        exp_err   = m_is_err(a);
        exp_rdata = 64'd0;
        if (!exp_err) begin
            if (w) begin
                for (int k = 0; k < 8; k++)
                    if (s[k]) m_mem[idx][8*k +: 8] = d[8*k +: 8];
            end else begin
                exp_rdata = m_mem[idx];
            end
        end
        pend = 1'b1;
        m_gnts++;
    endtask

    task automatic idle_cycle();
        @(posedge g_clk); #1;
        bus.mem_req = 1'b0;
        @(negedge g_clk);
        check_rsp();
        chk("idle_gnt", {63'd0, bus.mem_gnt}, 64'd0);
    endtask

    task automatic do_reset(input logic hold);
        @(posedge g_clk); #1;
        g_reset     = 1'b1;
        bus.mem_req = hold;
        @(negedge g_clk);
        chk("rst_gnt", {63'd0, bus.mem_gnt}, 64'd0);
        @(posedge g_clk); #1;
        g_reset     = 1'b0;
        bus.mem_req = 1'b0;
        pend        = 1'b0;
        m_lfsr      = 16'hACE1;
        m_gnts      = 0;
        @(negedge g_clk);
        check_rsp();
        chk("rst_gnt_after", {63'd0, bus.mem_gnt}, 64'd0);
        chk("rst_txn", {32'd0, txn_count}, 64'd0);
        chk("rst_proto", {63'd0, proto_err}, 64'd0);
    endtask

    // Step the model until the next request will stall, using real reads.
    task automatic seek_stall();
        for (int i = 0; i < 32 && m_draw() == 0; i++)
            run_txn(64'h40, 1'b0, 8'h00, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] a;
        int          kind;
        n_chk         = 0;
        n_fail        = 0;
        m_gnts        = 0;
        pend          = 1'b0;
        g_reset       = 1'b1;
        stall_en      = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_addr  = 64'd0;
        bus.mem_wen   = 1'b0;
        bus.mem_strb  = 8'd0;
        bus.mem_wdata = 64'd0;
        m_lfsr        = 16'hACE1;
        do_reset(1'b0);

        // Fill the non-error half of the store so every read is defined.
        for (int i = 0; i < 512; i++)
            run_txn(64'(i) << 3, 1'b1, 8'hFF, {$urandom, $urandom});

        run_txn(64'h40, 1'b1, 8'hFF, 64'h1122334455667788);
        run_txn(64'h40, 1'b0, 8'h00, 64'd0);
        idle_cycle();
        chk("dir_full_rd", last_rdata, 64'h1122334455667788);
        chk("dir_full_err", {63'd0, last_err}, 64'd0);

        run_txn(64'h40, 1'b1, 8'h0F, 64'hAAAAAAAAAAAAAAAA);
        run_txn(64'h40, 1'b0, 8'h00, 64'd0);
        idle_cycle();
        chk("dir_part_rd", last_rdata, 64'h11223344AAAAAAAA);

        run_txn(64'h1008, 1'b0, 8'h00, 64'd0);
        idle_cycle();
        chk("rgn_err", {63'd0, last_err}, 64'd1);
        chk("rgn_rdata", last_rdata, 64'd0);
        run_txn(64'h2000_0000, 1'b0, 8'h00, 64'd0);
        idle_cycle();
        chk("oob_err", {63'd0, last_err}, 64'd1);
        chk("oob_rdata", last_rdata, 64'd0);
        run_txn(64'h2000_0040, 1'b1, 8'hFF, 64'hDEADBEEFDEADBEEF);
        run_txn(64'h1040, 1'b1, 8'hFF, 64'hDEADBEEFDEADBEEF);
        run_txn(64'h40, 1'b0, 8'h00, 64'd0);
        idle_cycle();
        chk("err_no_store", last_rdata, 64'h11223344AAAAAAAA);
        chk("dir_txn", {32'd0, txn_count}, 64'(m_gnts));

        stall_en = 1'b1;
        do_reset(1'b0);
        seen0 = 1'b0;
        seen4 = 1'b0;
        max_w = 0;
        for (int t = 0; t < 1000; t++) begin
            if ($urandom_range(3) == 0) idle_cycle();
            kind = int'($urandom_range(19));
            if (kind < 14)
                a = 64'($urandom_range(4095));
            else if (kind < 17)
                a = 64'h1000 + 64'($urandom_range(4095));
            else
                a = {$urandom, $urandom} | 64'h2000_0000_0000;
            run_txn(a, 1'($urandom_range(1)), 8'($urandom),
                    {$urandom, $urandom});
        end
        idle_cycle();
        chk("rand_txn", {32'd0, txn_count}, 64'd1000);
        chk("rand_seen0", {63'd0, seen0}, 64'd1);
        chk("rand_seen4", {63'd0, seen4}, 64'd1);
        chk("rand_maxw_ok", {63'd0, (max_w <= 4)}, 64'd1);

        seek_stall();
        @(posedge g_clk); #1;
        bus.mem_req  = 1'b1;
        bus.mem_addr = 64'h48;
        bus.mem_wen  = 1'b0;
        @(negedge g_clk);
        check_rsp();
        chk("drop_gnt0", {63'd0, bus.mem_gnt}, 64'd0);
        m_lfsr = m_step(m_lfsr);
        idle_cycle();
        idle_cycle();
        chk("proto_err", {63'd0, proto_err}, 64'd1);
        chk("drop_txn", {32'd0, txn_count}, 64'(m_gnts));
        repeat (3) idle_cycle();
        chk("proto_sticky", {63'd0, proto_err}, 64'd1);

        seek_stall();
        @(posedge g_clk); #1;
        bus.mem_req  = 1'b1;
        bus.mem_addr = 64'h80;
        bus.mem_wen  = 1'b0;
        @(negedge g_clk);
        check_rsp();
        chk("wait_gnt0", {63'd0, bus.mem_gnt}, 64'd0);
        do_reset(1'b1);

        run_txn(64'h80, 1'b1, 8'hFF, 64'h0123456789ABCDEF);
        run_txn(64'h80, 1'b0, 8'h00, 64'd0);
        do_reset(1'b0);
        run_txn(64'h80, 1'b0, 8'h00, 64'd0);
        idle_cycle();
        chk("keep_after_rst", last_rdata, 64'h0123456789ABCDEF);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
